// File: rtl/parking_pkg.sv
// Shared types for the parking occupancy controller: gate state
// encoding, sensor codes and a small popcount helper.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENT0    = 3'd1,
    ENT1    = 3'd2,
    ENT2    = 3'd3,
    EXT0    = 3'd4,
    EXT1    = 3'd5,
    EXT2    = 3'd6,
    INVALID = 3'd7
  } gate_state_t;

  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_OUT  = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;
  localparam logic [1:0] AB_IN   = 2'b01;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/parking_occupancy_ctrl_if.sv
// Sensor, clear and status bundle of the occupancy controller.
// master = sensor/host side, slave = controller.
interface parking_occupancy_ctrl_if #(
  parameter int NUM_GATES = 2,
  parameter int CAPACITY  = 100
);
  localparam int CNT_W = $clog2(CAPACITY + 1);

  logic                 clr;
  logic [NUM_GATES-1:0] a;
  logic [NUM_GATES-1:0] b;
  logic [CNT_W-1:0]     occupancy;
  logic                 full;
  logic                 empty;
  logic [NUM_GATES-1:0] gate_inc;
  logic [NUM_GATES-1:0] gate_dec;
  logic [NUM_GATES-1:0] gate_err;
  logic                 ovf_err;
  logic                 unf_err;

  modport master (
    output clr, a, b,
    input  occupancy, full, empty,
    input  gate_inc, gate_dec, gate_err,
    input  ovf_err, unf_err
  );

  modport slave (
    input  clr, a, b,
    output occupancy, full, empty,
    output gate_inc, gate_dec, gate_err,
    output ovf_err, unf_err
  );

endinterface

// File: rtl/parking_gate_fsm.sv
// Per-lane direction FSM: tracks the a/b sensor walk and flags a
// completed entry, a completed exit, or an illegal sensor jump.
module parking_gate_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter_ev,
  output logic exit_ev,
  output logic invalid
);

  gate_state_t state;
  gate_state_t nxt;
  logic [1:0]  ab;

  assign ab = {a, b};

  // next-state decode of the sensor walk
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        unique case (ab)
          AB_OUT:  nxt = ENT0;
          AB_IN:   nxt = EXT0;
          AB_BOTH: nxt = INVALID;
          default: nxt = IDLE;
        endcase
      end
      ENT0: begin
        unique case (ab)
          AB_BOTH: nxt = ENT1;
          AB_NONE: nxt = IDLE;
          AB_IN:   nxt = INVALID;
          default: nxt = ENT0;
        endcase
      end
      ENT1: begin
        unique case (ab)
          AB_IN:   nxt = ENT2;
          AB_OUT:  nxt = ENT0;
          AB_NONE: nxt = INVALID;
          default: nxt = ENT1;
        endcase
      end
      ENT2: begin
        unique case (ab)
          AB_NONE: nxt = IDLE;
          AB_BOTH: nxt = ENT1;
          AB_OUT:  nxt = INVALID;
          default: nxt = ENT2;
        endcase
      end
      EXT0: begin
        unique case (ab)
          AB_BOTH: nxt = EXT1;
          AB_NONE: nxt = IDLE;
          AB_OUT:  nxt = INVALID;
          default: nxt = EXT0;
        endcase
      end
      EXT1: begin
        unique case (ab)
          AB_OUT:  nxt = EXT2;
          AB_IN:   nxt = EXT0;
          AB_NONE: nxt = INVALID;
          default: nxt = EXT1;
        endcase
      end
      EXT2: begin
        unique case (ab)
          AB_NONE: nxt = IDLE;
          AB_BOTH: nxt = EXT1;
          AB_IN:   nxt = INVALID;
          default: nxt = EXT2;
        endcase
      end
      default: begin
        nxt = (ab == AB_NONE) ? IDLE : INVALID;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  assign enter_ev = (state == ENT2) && (ab == AB_NONE);
  assign exit_ev  = (state == EXT2) && (ab == AB_NONE);
  assign invalid  = (nxt == INVALID) && (state != INVALID);

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-gate occupancy controller: merges gate events into a
// saturating count. Option macro: PARKING_SENSOR_SYNC_EN.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_GATES = 2,
  parameter int CAPACITY  = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  parking_occupancy_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(CAPACITY + 1);
  // wide enough for an 8-gate burst on a 1-bit counter
  localparam int SW    = CNT_W + 5;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [NUM_GATES-1:0] a_s;
  logic [NUM_GATES-1:0] b_s;

`ifdef PARKING_SENSOR_SYNC_EN
  logic [NUM_GATES-1:0] a_m;
  logic [NUM_GATES-1:0] b_m;

  // two-flop synchronizer for asynchronous sensor pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_m <= '0;
      b_m <= '0;
      a_s <= '0;
      b_s <= '0;
    end else begin
      a_m <= bus.a;
      b_m <= bus.b;
      a_s <= a_m;
      b_s <= b_m;
    end
  end
`else
  assign a_s = bus.a;
  assign b_s = bus.b;
`endif

  logic [NUM_GATES-1:0] enter_ev;
  logic [NUM_GATES-1:0] exit_ev;
  logic [NUM_GATES-1:0] invalid;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    parking_gate_fsm u_fsm (
      .clk      (clk),
      .reset    (reset),
      .a        (a_s[g]),
      .b        (b_s[g]),
      .enter_ev (enter_ev[g]),
      .exit_ev  (exit_ev[g]),
      .invalid  (invalid[g])
    );
  end

  logic [CNT_W-1:0]     occ;
  logic [NUM_GATES-1:0] inc_q;
  logic [NUM_GATES-1:0] dec_q;
  logic [NUM_GATES-1:0] gerr_q;
  logic                 ovf_q;
  logic                 unf_q;

  logic [3:0]           n_ent;
  logic [3:0]           n_ext;
  logic signed [SW-1:0] nxt;

  // enters and exits cancel before saturation is applied
  always_comb begin
    n_ent = popcnt8(8'(enter_ev));
    n_ext = popcnt8(8'(exit_ev));
    nxt   = SW'(occ) + SW'(n_ent) - SW'(n_ext);
  end

  // saturating counter, event pulses and sticky errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ    <= '0;
      inc_q  <= '0;
      dec_q  <= '0;
      gerr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (bus.clr) begin
      occ    <= '0;
      inc_q  <= '0;
      dec_q  <= '0;
      gerr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      inc_q  <= enter_ev;
      dec_q  <= exit_ev;
      gerr_q <= gerr_q | invalid;
      if (nxt > CAP_S) begin
        occ   <= CNT_W'(CAPACITY);
        ovf_q <= 1'b1;
      end else if (nxt[SW-1]) begin
        occ   <= '0;
        unf_q <= 1'b1;
      end else begin
        occ <= nxt[CNT_W-1:0];
      end
    end
  end

  assign bus.occupancy = occ;
  assign bus.full      = (occ == CNT_W'(CAPACITY));
  assign bus.empty     = (occ == '0);
  assign bus.gate_inc  = inc_q;
  assign bus.gate_dec  = dec_q;
  assign bus.gate_err  = gerr_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Bench for parking_occupancy_ctrl: sensor-walk winding model plus
// directed lane sequences with hand-computed expectations.
module tb_parking_occupancy_ctrl;

  localparam int NG  = 2;
  localparam int CAP = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  parking_occupancy_ctrl_if #(.NUM_GATES(NG), .CAPACITY(CAP)) bus ();

  parking_occupancy_ctrl #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: sensor codes sit on a ring 00->10->11->01->00. A lane
  // accumulates its signed walk since leaving 00; a jump across the
  // ring is illegal, and returning to 00 after +4 / -4 is a car in/out.
  int      wind [NG];
  bit      inv  [NG];
  int      m_occ  = 0;
  bit      m_ovf  = 0;
  bit      m_unf  = 0;
  logic [NG-1:0] m_inc  = '0;
  logic [NG-1:0] m_dec  = '0;
  logic [NG-1:0] m_gerr = '0;
  logic [NG-1:0] sa1 = '0, sb1 = '0, sa2 = '0, sb2 = '0;

  function automatic int ring(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [NG-1:0] pa, pb, ei, xi, er;
    int r, cur, dl, t;
    if (reset) begin
      for (int g = 0; g < NG; g++) begin
        wind[g] = 0;
        inv[g]  = 0;
      end
      m_occ = 0; m_ovf = 0; m_unf = 0;
      m_inc = '0; m_dec = '0; m_gerr = '0;
      sa1 = '0; sb1 = '0; sa2 = '0; sb2 = '0;
    end else begin
`ifdef PARKING_SENSOR_SYNC_EN
      pa = sa2; pb = sb2;
      sa2 = sa1; sb2 = sb1;
      sa1 = bus.a; sb1 = bus.b;
`else
      pa = bus.a; pb = bus.b;
`endif
      ei = '0; xi = '0; er = '0;
      for (int g = 0; g < NG; g++) begin
        r = ring({pa[g], pb[g]});
        if (inv[g]) begin
          if (r == 0) inv[g] = 0;
        end else begin
          cur = ((wind[g] % 4) + 4) % 4;
          dl  = (r - cur + 4) % 4;
          if (dl == 2) begin
            inv[g]  = 1;
            wind[g] = 0;
            er[g]   = 1'b1;
          end else begin
            wind[g] += (dl == 3) ? -1 : dl;
            if (r == 0) begin
              if (wind[g] == 4)  ei[g] = 1'b1;
              if (wind[g] == -4) xi[g] = 1'b1;
              wind[g] = 0;
            end
          end
        end
      end
      if (bus.clr) begin
        m_occ = 0; m_ovf = 0; m_unf = 0;
        m_inc = '0; m_dec = '0; m_gerr = '0;
      end else begin
        t = m_occ + $countones(ei) - $countones(xi);
        if (t > CAP) begin
          m_occ = CAP; m_ovf = 1;
        end else if (t < 0) begin
          m_occ = 0; m_unf = 1;
        end else begin
          m_occ = t;
        end
        m_inc  = ei;
        m_dec  = xi;
        m_gerr = m_gerr | er;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("occupancy", int'(bus.occupancy), m_occ);
    chk("full", int'(bus.full), int'(m_occ == CAP));
    chk("empty", int'(bus.empty), int'(m_occ == 0));
    chk("gate_inc", int'(bus.gate_inc), int'(m_inc));
    chk("gate_dec", int'(bus.gate_dec), int'(m_dec));
    chk("gate_err", int'(bus.gate_err), int'(m_gerr));
    chk("ovf_err", int'(bus.ovf_err), int'(m_ovf));
    chk("unf_err", int'(bus.unf_err), int'(m_unf));
  end

  task automatic drv(input logic [NG-1:0] av, input logic [NG-1:0] bv);
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
  endtask

  task automatic gab(input int g, input logic [1:0] ab);
    logic [NG-1:0] av, bv;
    av = '0;
    bv = '0;
    av[g] = ab[1];
    bv[g] = ab[0];
    drv(av, bv);
  endtask

  task automatic run(input int g, input logic [1:0] c0, input logic [1:0] c1,
                     input logic [1:0] c2, input logic [1:0] c3);
    gab(g, c0); gab(g, c1); gab(g, c2); gab(g, c3);
  endtask

  task automatic enter(input int g);
    run(g, 2'b10, 2'b11, 2'b01, 2'b00);
  endtask

  task automatic leave(input int g);
    run(g, 2'b01, 2'b11, 2'b10, 2'b00);
  endtask

  task automatic settle();
`ifdef PARKING_SENSOR_SYNC_EN
    repeat (2) @(posedge clk);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.a   = '0;
    bus.b   = '0;
    bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_occ", int'(bus.occupancy), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_err", int'({bus.gate_err, bus.ovf_err, bus.unf_err}), 0);
    reset = 1'b0;
    drv('0, '0);

    enter(0);
    settle();
    chk("ent_occ", int'(bus.occupancy), 1);
    chk("ent_inc", int'(bus.gate_inc), 1);
    chk("ent_empty", int'(bus.empty), 0);

    leave(1);
    settle();
    chk("ext_occ", int'(bus.occupancy), 0);
    chk("ext_dec", int'(bus.gate_dec), 2);
    chk("ext_empty", int'(bus.empty), 1);
    chk("ext_unf", int'(bus.unf_err), 0);

    leave(1);
    settle();
    chk("unf_occ", int'(bus.occupancy), 0);
    chk("unf_dec", int'(bus.gate_dec), 2);
    chk("unf_set", int'(bus.unf_err), 1);
    do_clr();
    chk("clr_unf", int'(bus.unf_err), 0);

    enter(0); enter(0); enter(0);
    settle();
    chk("fill_occ", int'(bus.occupancy), 3);
    chk("fill_full", int'(bus.full), 1);

    drv(2'b01, 2'b10);
    drv(2'b11, 2'b11);
    drv(2'b10, 2'b01);
    drv(2'b00, 2'b00);
    settle();
    chk("both_occ", int'(bus.occupancy), 3);
    chk("both_ovf", int'(bus.ovf_err), 0);
    chk("both_inc", int'(bus.gate_inc), 1);
    chk("both_dec", int'(bus.gate_dec), 2);

    enter(0);
    settle();
    chk("ovf_occ", int'(bus.occupancy), 3);
    chk("ovf_set", int'(bus.ovf_err), 1);
    chk("ovf_inc", int'(bus.gate_inc), 1);

    run(0, 2'b10, 2'b11, 2'b10, 2'b00);
    settle();
    chk("back_inc", int'(bus.gate_inc), 0);
    chk("back_occ", int'(bus.occupancy), 3);

    do_clr();
    chk("clr_occ", int'(bus.occupancy), 0);
    chk("clr_ovf", int'(bus.ovf_err), 0);

    gab(0, 2'b00);
    gab(0, 2'b11);
    settle();
    chk("inv_err", int'(bus.gate_err), 1);
    run(0, 2'b10, 2'b11, 2'b01, 2'b00);
    settle();
    chk("inv_hold_occ", int'(bus.occupancy), 0);
    chk("inv_hold_inc", int'(bus.gate_inc), 0);
    enter(0);
    settle();
    chk("inv_rec_occ", int'(bus.occupancy), 1);
    chk("inv_sticky", int'(bus.gate_err), 1);

    gab(0, 2'b10);
    gab(0, 2'b11);
    gab(0, 2'b01);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_occ", int'(bus.occupancy), 0);
    chk("mid_rst_err", int'(bus.gate_err), 0);
    @(negedge clk);
    reset = 1'b0;
    gab(0, 2'b01);
    gab(0, 2'b00);
    settle();
    chk("post_rst_inc", int'(bus.gate_inc), 0);
    chk("post_rst_dec", int'(bus.gate_dec), 0);
    chk("post_rst_occ", int'(bus.occupancy), 0);

    gab(0, 2'b11);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    settle();
    chk("rst11_err", int'(bus.gate_err), 1);
    gab(0, 2'b00);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
